cdb_req_buffer: RTL and testbench

//  FU-side initiator of the CDB request/grant protocol: one instance per functional unit.

---
 rtl/cdb_req_buffer_pkg.sv | 34 +++
 rtl/cdb_req_fifo.sv | 56 +++++
 rtl/cdb_req_buffer.sv | 79 +++++++
 tb/tb_cdb_req_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_req_buffer_pkg.sv
// Shared types and constants for the FU-side CDB request buffer.
// Build option CDB_REQ_BYPASS_EN (see cdb_req_buffer) needs nothing from this package.
package cdb_req_buffer_pkg;

   localparam int unsigned PHYS_TAG_W        = 6;
   localparam int unsigned DATA_W            = 32;
   localparam int unsigned CDB_REQ_DEPTH     = 4;
   localparam int unsigned CDB_URGENT_CYCLES = 8;

   typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
   typedef logic [DATA_W-1:0]     data_t;

   // Result payload as stored in the FIFO
   typedef struct packed {
      phys_tag_t tag;
      data_t     data;
   } cdb_payload_t;

   // Entry driven onto the CDB arbiter's fu_outputs
   typedef struct packed {
      logic      valid;
      phys_tag_t tag;
      data_t     data;
   } cdb_entry_t;

   function automatic cdb_entry_t make_entry(input logic valid, input cdb_payload_t p);
      cdb_entry_t e;
      e.valid = valid;
      e.tag   = p.tag;
      e.data  = p.data;
      return e;
   endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// Parameterized circular FIFO with push/pop/flush; head reads as zero when empty.
// Push is accepted while full only when a pop happens the same cycle.
module cdb_req_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 8,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      empty   = (count == '0);
      full    = (count == CW'(DEPTH));
      do_pop  = pop && !empty && !flush;
      do_push = push && (!full || do_pop) && !flush;
      head    = empty ? '0 : mem[rd_ptr];
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/cdb_req_buffer.sv
// FU-side CDB initiator: buffers results, requests the bus, pops on grant, flags long waits.
// Define CDB_REQ_BYPASS_EN to let a result reach the CDB in the same cycle when the buffer is empty.
module cdb_req_buffer
   import cdb_req_buffer_pkg::*;
#(
   parameter int unsigned DEPTH         = CDB_REQ_DEPTH,
   parameter int unsigned URGENT_CYCLES = CDB_URGENT_CYCLES,
   localparam int unsigned OW           = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          fu_valid,
   input  phys_tag_t     fu_tag,
   input  data_t         fu_data,
   output logic          fu_stall,
   input  logic          flush,
   output logic          request,
   input  logic          grant,
   output cdb_entry_t    cdb_entry,
   output logic          req_urgent,
   output logic [OW-1:0] occupancy
);

   cdb_payload_t fu_payload;
   cdb_payload_t fifo_head;
   cdb_payload_t entry_payload;
   logic         fifo_full;
   logic         fifo_empty;
   logic         fifo_push;
   logic         fifo_pop;
   logic         bypass;
   logic [7:0]   wait_cnt;

   always_comb begin
      fu_payload.tag  = fu_tag;
      fu_payload.data = fu_data;
`ifdef CDB_REQ_BYPASS_EN
      bypass = fifo_empty && fu_valid && !flush;
`else
      bypass = 1'b0;
`endif
      request       = !fifo_empty || bypass;
      entry_payload = bypass ? fu_payload : fifo_head;
      cdb_entry     = make_entry(request, entry_payload);
      fifo_pop      = grant && !fifo_empty;
      // A bypassed result that wins the grant never enters the FIFO
      fifo_push     = fu_valid && !(bypass && grant);
      fu_stall      = fifo_full;
      req_urgent    = request && (wait_cnt >= 8'(URGENT_CYCLES));
   end

   cdb_req_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(cdb_payload_t))
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (flush),
      .wdata (fu_payload),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occupancy)
   );

   // Cycles the current head has been requesting without a grant
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wait_cnt <= '0;
      end else if (request && !grant) begin
         if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_cdb_req_buffer.sv
// Self-checking bench for cdb_req_buffer: queue-based reference model checked every cycle
// plus directed scenarios with hand-computed expectations (both CDB_REQ_BYPASS_EN builds).
module tb_cdb_req_buffer;
   import cdb_req_buffer_pkg::*;

   localparam int unsigned DEPTH = CDB_REQ_DEPTH;
   localparam int unsigned URG   = CDB_URGENT_CYCLES;
   localparam int unsigned OW    = $clog2(DEPTH + 1);
`ifdef CDB_REQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          fu_valid;
   phys_tag_t     fu_tag;
   data_t         fu_data;
   logic          fu_stall;
   logic          flush;
   logic          request;
   logic          grant;
   cdb_entry_t    cdb_entry;
   logic          req_urgent;
   logic [OW-1:0] occupancy;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   cdb_req_buffer dut (
      .clock      (clock),
      .reset      (reset),
      .fu_valid   (fu_valid),
      .fu_tag     (fu_tag),
      .fu_data    (fu_data),
      .fu_stall   (fu_stall),
      .flush      (flush),
      .request    (request),
      .grant      (grant),
      .cdb_entry  (cdb_entry),
      .req_urgent (req_urgent),
      .occupancy  (occupancy)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Reference model: list of buffered results plus how long the head has waited
   cdb_payload_t mq[$];
   int           mwait = 0;
   bit           model_ok = 1'b0;
   bit           m_byp, m_req, m_pop;
   int           m_sz;
   cdb_entry_t   m_ent;
   cdb_payload_t m_in;

   always begin
      @(negedge clock);
      #2;
      m_sz      = mq.size();
      m_byp     = BYP && (m_sz == 0) && fu_valid && !flush;
      m_req     = (m_sz != 0) || m_byp;
      m_ent     = '0;
      m_ent.valid = m_req;
      if (m_sz != 0) begin
         m_ent.tag  = mq[0].tag;
         m_ent.data = mq[0].data;
      end else if (m_byp) begin
         m_ent.tag  = fu_tag;
         m_ent.data = fu_data;
      end
      if (model_ok) begin
         chk("m_request", 64'(request), 64'(m_req));
         chk("m_entry", 64'(cdb_entry), 64'(m_ent));
         chk("m_stall", 64'(fu_stall), 64'(m_sz == int'(DEPTH)));
         chk("m_occupancy", 64'(occupancy), 64'(m_sz));
         chk("m_urgent", 64'(req_urgent), 64'(m_req && (mwait >= int'(URG))));
      end
      if (reset || flush) begin
         mq.delete();
         mwait = 0;
         if (reset) model_ok = 1'b1;
      end else begin
         m_pop = grant && (m_sz != 0);
         if (grant && m_req)  mwait = 0;
         else if (m_req)      mwait = (mwait < 255) ? mwait + 1 : 255;
         else                 mwait = 0;
         if (m_pop) void'(mq.pop_front());
         if (fu_valid && !(m_byp && grant) && ((m_sz < int'(DEPTH)) || m_pop)) begin
            m_in.tag  = fu_tag;
            m_in.data = fu_data;
            mq.push_back(m_in);
         end
      end
   end

   // One cycle of stimulus; returns mid-cycle so this cycle's outputs can be checked
   task automatic cyc(input logic fv, input logic [7:0] tag, input data_t d,
                      input logic g, input logic fl);
      @(negedge clock);
      reset    = 1'b0;
      fu_valid = fv;
      fu_tag   = PHYS_TAG_W'(tag);
      fu_data  = d;
      grant    = g;
      flush    = fl;
      #3;
   endtask

   task automatic idle(input logic g);
      cyc(1'b0, 8'd0, '0, g, 1'b0);
   endtask

   task automatic rst_cyc();
      @(negedge clock);
      reset    = 1'b1;
      fu_valid = 1'b0;
      grant    = 1'b0;
      flush    = 1'b0;
      #3;
   endtask

   initial begin
      reset = 1'b1; fu_valid = 1'b0; fu_tag = '0; fu_data = '0; grant = 1'b0; flush = 1'b0;

      // Reset state
      rst_cyc(); rst_cyc();
      idle(1'b0);
      chk("rst_request", 64'(request), 64'(0));
      chk("rst_valid", 64'(cdb_entry.valid), 64'(0));
      chk("rst_stall", 64'(fu_stall), 64'(0));
      chk("rst_occ", 64'(occupancy), 64'(0));
      // Grant with nothing buffered is ignored
      idle(1'b1);
      chk("empty_grant_occ", 64'(occupancy), 64'(0));

      // Single push then grant
      cyc(1'b1, 8'd10, 32'hDEADBEEF, 1'b0, 1'b0);
      idle(1'b0);
      chk("t2_request", 64'(request), 64'(1));
      chk("t2_entry", 64'(cdb_entry), {25'd0, 1'b1, 6'd10, 32'hDEADBEEF});
      chk("t2_occ", 64'(occupancy), 64'(1));
      idle(1'b1);
      idle(1'b0);
      chk("t2_empty_occ", 64'(occupancy), 64'(0));
      chk("t2_empty_req", 64'(request), 64'(0));

      // Fill to full, then push+pop while full
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'(30 + i), data_t'(32'h100 + i), 1'b0, 1'b0);
      idle(1'b0);
      chk("t3_stall", 64'(fu_stall), 64'(1));
      chk("t3_occ", 64'(occupancy), 64'(4));
      chk("t3_head", 64'(cdb_entry.tag), 64'(30));
      cyc(1'b1, 8'd34, 32'h134, 1'b1, 1'b0);
      idle(1'b0);
      chk("t3_occ_after", 64'(occupancy), 64'(4));
      chk("t3_head_after", 64'(cdb_entry.tag), 64'(31));
      for (int k = 0; k < 4; k++) begin
         idle(1'b1);
         chk("t3_order", 64'(cdb_entry.tag), 64'(31 + k));
      end
      idle(1'b0);
      chk("t3_drained", 64'(occupancy), 64'(0));

      // Urgency: head requesting ungranted reaches URG waited cycles
      cyc(1'b1, 8'd50, 32'h50, 1'b0, 1'b0);
      cyc(1'b1, 8'd51, 32'h51, 1'b0, 1'b0);
      cyc(1'b1, 8'd52, 32'h52, 1'b1, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         idle(1'b0);
         chk("t4_urgent", 64'(req_urgent), 64'(k == 9));
      end
      idle(1'b1);
      chk("t4_urgent_grant_cycle", 64'(req_urgent), 64'(1));
      idle(1'b0);
      chk("t4_urgent_cleared", 64'(req_urgent), 64'(0));
      chk("t4_next_head", 64'(cdb_entry.tag), 64'(52));
      idle(1'b1);

      // Flush overrides simultaneous push and grant
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'(60 + i), data_t'(32'h600 + i), 1'b0, 1'b0);
      idle(1'b0);
      chk("t5_occ3", 64'(occupancy), 64'(3));
      cyc(1'b1, 8'd63, 32'h663, 1'b1, 1'b1);
      idle(1'b0);
      chk("t5_occ", 64'(occupancy), 64'(0));
      chk("t5_request", 64'(request), 64'(0));
      chk("t5_urgent", 64'(req_urgent), 64'(0));

      // Reset in the middle of operation
      cyc(1'b1, 8'd20, 32'h20, 1'b0, 1'b0);
      cyc(1'b1, 8'd21, 32'h21, 1'b0, 1'b0);
      rst_cyc();
      idle(1'b0);
      chk("midrst_occ", 64'(occupancy), 64'(0));
      chk("midrst_entry", 64'(cdb_entry), 64'(0));

      // Result arriving at an empty buffer together with a grant
      cyc(1'b1, 8'd42, 32'hFEDCBA98, 1'b1, 1'b0);
`ifdef CDB_REQ_BYPASS_EN
      chk("t6_entry", 64'(cdb_entry), {25'd0, 1'b1, 6'd42, 32'hFEDCBA98});
      chk("t6_occ_same", 64'(occupancy), 64'(0));
      idle(1'b0);
      chk("t6_occ_granted", 64'(occupancy), 64'(0));
      cyc(1'b1, 8'd42, 32'hFEDCBA98, 1'b0, 1'b0);
      chk("t6_req_same", 64'(request), 64'(1));
      idle(1'b0);
      chk("t6_occ_ungranted", 64'(occupancy), 64'(1));
`else
      chk("t6_req_same", 64'(request), 64'(0));
      idle(1'b0);
      chk("t6_occ_next", 64'(occupancy), 64'(1));
      chk("t6_entry_next", 64'(cdb_entry), {25'd0, 1'b1, 6'd42, 32'hFEDCBA98});
`endif
      idle(1'b1);
      idle(1'b0);
      chk("t6_final_occ", 64'(occupancy), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
